// File: rtl/uart_word_sender.sv
// Splits 1-4 byte MMIO payloads into bytes for UartTx, LSB first.
// A FIFO absorbs core bursts; a four-state FSM paces start pulses against tx_busy.
module uart_word_sender #(
  parameter int FIFO_AW = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  input  logic [1:0]         in_len,
  output logic               in_ready,
  output logic               tx_start,
  output logic [7:0]         sdata,
  input  logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               idle
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {IDLE, START, GUARD, WAIT} state_t;
  state_t state, state_n;

  logic [31:0]        mem_data [DEPTH];
  logic [1:0]         mem_len  [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [31:0]        shreg;
  logic [1:0]         len_r, idx;
  logic               push, pop, advance;

  // Ready comes only from the registered count, so a full FIFO stays closed
  // during the cycle it pops.
  assign in_ready   = (count != FULL);
  assign push       = in_valid & in_ready;
  assign pop        = (state == IDLE) & (count != '0);
  assign advance    = (state == WAIT) & ~tx_busy & (idx != len_r);
  assign sdata      = shreg[7:0];
  assign fifo_count = count;
  assign idle       = (state == IDLE) & (count == '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data;
      mem_len[wr_ptr]  <= in_len;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      shreg  <= '0;
      len_r  <= '0;
      idx    <= '0;
    end else begin
      state <= state_n;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        shreg  <= mem_data[rd_ptr];
        len_r  <= mem_len[rd_ptr];
        idx    <= '0;
      end else if (advance) begin
        shreg <= shreg >> 8;
        idx   <= idx + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    case (state)
      IDLE:  if (count != '0) state_n = START;
      START: if (!tx_busy) begin
        tx_start = 1'b1;
        state_n  = GUARD;
      end
      // UartTx raises busy a cycle after the start pulse, so skip one sample.
      GUARD: state_n = WAIT;
      WAIT:  if (!tx_busy) state_n = (idx == len_r) ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_word_sender.sv
// Scoreboard bench for uart_word_sender: expected bytes queued on accepted push,
// popped on each tx_start; a small UartTx model supplies tx_busy.
module tb_uart_word_sender;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_len;
  logic        in_ready;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy;
  logic [4:0]  fifo_count;
  logic        idle;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int accepted = 0;
  int busy_len = 20;
  int busy_cnt;
  logic ext_busy = 1'b0;
  logic prev_start;
  logic [7:0] exp_q[$];

  uart_word_sender #(.FIFO_AW(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_len(in_len), .in_ready(in_ready), .tx_start(tx_start), .sdata(sdata),
    .tx_busy(tx_busy), .fifo_count(fifo_count), .idle(idle)
  );

  always #5 clock = ~clock;

  // UartTx model: busy from the cycle after a start pulse for busy_len cycles.
  always @(posedge clock) begin
    if (reset) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) | ext_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) prev_start <= 1'b0;
    else begin
      if (tx_start) begin
        pulses++;
        chk("start_while_busy", {31'd0, tx_busy}, 32'd0);
        chk("back_to_back_start", {31'd0, prev_start}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else chk("sdata", {24'd0, sdata}, {24'd0, exp_q.pop_front()});
      end
      prev_start <= tx_start;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push_word(input logic [1:0] len, input logic [31:0] data);
    int n = 0;
    in_valid = 1'b1; in_len = len; in_data = data;
    while (!in_ready && n < 600) begin @(negedge clock); n++; end
    if (!in_ready) begin
      chk("push_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    for (int b = 0; b <= int'(len); b++) exp_q.push_back(data[8*b +: 8]);
    accepted++;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < 3000) begin @(negedge clock); n++; end
    chk(tag, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    int p0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_sdata", {24'd0, sdata}, 32'd0);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);

    // 1: four-byte word, LSB first, with first-byte latency
    p0 = pulses;
    push_word(2'd3, 32'h44332211);
    chk("lat_count", {27'd0, fifo_count}, 32'd1);
    chk("lat_no_start", {31'd0, tx_start}, 32'd0);
    chk("lat_not_idle", {31'd0, idle}, 32'd0);
    @(negedge clock);
    chk("lat_start", {31'd0, tx_start}, 32'd1);
    wait_idle("t1_idle");
    chk("t1_pulses", pulses - p0, 32'd4);

    // 2: single byte word; next word restarts at its own byte 0
    busy_len = 5;
    p0 = pulses;
    push_word(2'd0, 32'hDEADBE41);
    push_word(2'd1, 32'h7766BBAA);
    wait_idle("t2_idle");
    chk("t2_pulses", pulses - p0, 32'd3);

    // 3/4: fill while UartTx is owned elsewhere, then full push+pop cycle
    ext_busy = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 17; i++) push_word(2'd0, 32'h0000_0050 + i);
    chk("full_count", {27'd0, fifo_count}, 32'd16);
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    chk("busy_no_start", pulses - p0, 32'd0);
    fork
      push_word(2'd0, 32'h0000_0061);
      begin
        int n = 0;
        repeat (10) @(negedge clock);
        chk("held_while_full", accepted, 32'd20);
        ext_busy = 1'b0;
        while (fifo_count == 5'd16 && n < 200) begin @(negedge clock); n++; end
        chk("full_pop_count", {27'd0, fifo_count}, 32'd15);
        chk("full_push_refused", accepted, 32'd20);
      end
    join
    wait_idle("t3_idle");
    chk("t3_pulses", pulses - p0, 32'd18);

    // 5: another master holds busy as START is entered
    ext_busy = 1'b1;
    p0 = pulses;
    push_word(2'd0, 32'h000000C5);
    repeat (10) @(negedge clock);
    chk("t5_held", pulses - p0, 32'd0);
    ext_busy = 1'b0;
    wait_idle("t5_idle");
    chk("t5_pulses", pulses - p0, 32'd1);

    // 6: reset during WAIT of byte 2 with entries queued
    busy_len = 20;
    p0 = pulses;
    push_word(2'd3, 32'hA4A3A2A1);
    push_word(2'd3, 32'hB4B3B2B1);
    push_word(2'd3, 32'hC4C3C2C1);
    push_word(2'd3, 32'hD4D3D2D1);
    while (pulses - p0 < 2) @(negedge clock);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_count", {27'd0, fifo_count}, 32'd0);
    chk("t6_idle", {31'd0, idle}, 32'd1);
    chk("t6_tx_start", {31'd0, tx_start}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    p0 = pulses;
    repeat (200) @(negedge clock);
    chk("t6_no_more", pulses - p0, 32'd0);
    chk("t6_idle_end", {31'd0, idle}, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
